alu_issue_queue: RTL and testbench

- Upstream feed stage for the 4-bit ALU (ports in1/in2/alu_mode -> 8-bit out).
- Accepts operation requests {mode, in1, in2} over a valid/ready handshake and buffers them in a FIFO.
- Drives one registered operation per cycle into the combinational ALU and captures the 8-bit ALU result into an output register with its own valid/ready handshake.
- Replaces the hand-driven stimulus in front of the ALU with a back-pressured pipeline.

---
 rtl/alu_issue_queue.sv | 115 +++++++++++
 tb/tb_alu_issue_queue.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_queue.sv
// alu_issue_queue: valid/ready request FIFO feeding a registered ALU issue stage and a result register.
// Define ALU_ISSUE_STATS_EN to add the ops_done / stall_cycles counter outputs.
module alu_issue_queue #(
  parameter int         DEPTH     = 4,
  parameter logic [3:0] IDLE_MODE = 4'b1111
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [3:0]               s_in1,
  input  logic [3:0]               s_in2,
  input  logic [3:0]               s_mode,
  output logic [3:0]               alu_in1,
  output logic [3:0]               alu_in2,
  output logic [3:0]               alu_mode,
  input  logic [7:0]               alu_out,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [7:0]               res_data,
  output logic [3:0]               res_mode,
  output logic [$clog2(DEPTH):0]   count
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [15:0]              ops_done,
  output logic [15:0]              stall_cycles
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [11:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [11:0]   head;
  logic          iss_valid;
  logic          adv;
  logic          push;
  logic          pop;

  assign s_ready = (count < FULL_C);
  assign adv     = !res_valid || res_ready;
  assign push    = s_valid && s_ready;
  assign pop     = adv && (count != '0);
  assign head    = mem[rd_ptr];

  // Request FIFO: entry packs {mode, in1, in2}; storage itself is never reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {s_mode, s_in1, s_in2};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Issue stage: holds ALU inputs steady whenever the result stage is stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      iss_valid <= 1'b0;
      alu_in1   <= '0;
      alu_in2   <= '0;
      alu_mode  <= IDLE_MODE;
    end else if (adv) begin
      iss_valid <= pop;
      if (pop) begin
        {alu_mode, alu_in1, alu_in2} <= head;
      end else begin
        alu_in1  <= '0;
        alu_in2  <= '0;
        alu_mode <= IDLE_MODE;
      end
    end
  end

  // Result stage: captures the combinational ALU output of the issued op
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_mode  <= '0;
    end else if (adv) begin
      res_valid <= iss_valid;
      if (iss_valid) begin
        res_data <= alu_out;
        res_mode <= alu_mode;
      end
    end
  end

`ifdef ALU_ISSUE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ops_done     <= '0;
      stall_cycles <= '0;
    end else begin
      if (res_valid && res_ready)  ops_done     <= ops_done + 16'd1;
      if (res_valid && !res_ready) stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_queue.sv
// Self-checking bench for alu_issue_queue: directed scenarios plus randomized traffic
// scored against an in-order queue of expected ALU results.
module tb_alu_issue_queue;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [3:0]    s_in1, s_in2, s_mode;
  logic [3:0]    alu_in1, alu_in2, alu_mode;
  logic [7:0]    alu_out;
  logic          res_valid;
  logic          res_ready;
  logic [7:0]    res_data;
  logic [3:0]    res_mode;
  logic [CW-1:0] count;
`ifdef ALU_ISSUE_STATS_EN
  logic [15:0]   ops_done;
  logic [15:0]   stall_cycles;
`endif

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0] mode;
    logic [7:0] data;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_ref(input logic [3:0] m, input logic [3:0] a, input logic [3:0] b);
    case (m)
      4'd0:    return {4'b0, a} + {4'b0, b};
      4'd1:    return {4'b0, a} * {4'b0, b};
      default: return {a ^ m, b};
    endcase
  endfunction

  assign alu_out = alu_ref(alu_mode, alu_in1, alu_in2);

  alu_issue_queue #(.DEPTH(DEPTH), .IDLE_MODE(4'b1111)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_in1(s_in1), .s_in2(s_in2), .s_mode(s_mode),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_mode(alu_mode),
    .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_mode(res_mode),
    .count(count)
`ifdef ALU_ISSUE_STATS_EN
    , .ops_done(ops_done), .stall_cycles(stall_cycles)
`endif
  );

  // Advance one clock; handshakes seen now complete at the coming edge.
  task automatic tick();
    exp_t e;
    exp_t h;
    if (rst) begin
      exp_q.delete();
    end else begin
      tests++;
      if (s_ready !== (count < CW'(DEPTH))) begin
        fails++;
        $display("FAIL s_ready_vs_count got %b count %0d", s_ready, count);
      end
      if (res_valid && res_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL sb_spurious got data %h mode %h, expected no result", res_data, res_mode);
        end else begin
          h = exp_q.pop_front();
          if (res_data !== h.data || res_mode !== h.mode) begin
            fails++;
            $display("FAIL sb_result got %h/%h expected %h/%h", res_data, res_mode, h.data, h.mode);
          end
        end
      end
      if (s_valid && s_ready) begin
        e.mode = s_mode;
        e.data = alu_ref(s_mode, s_in1, s_in2);
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] m, input logic [3:0] a, input logic [3:0] b);
    s_valid = 1'b1;
    s_mode  = m;
    s_in1   = a;
    s_in2   = b;
  endtask

  task automatic drain(input int budget);
    s_valid   = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < budget; i++) tick();
    tests++;
    if (exp_q.size() != 0 || count !== '0 || res_valid !== 1'b0) begin
      fails++;
      $display("FAIL drain got pending %0d count %0d res_valid %b, required 0/0/0", exp_q.size(), count, res_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    tests++;
    if (count !== '0 || s_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_fifo got count %0d s_ready %b, required 0/1", count, s_ready);
    end
    tests++;
    if (alu_in1 !== 4'd0 || alu_in2 !== 4'd0 || alu_mode !== 4'hF) begin
      fails++;
      $display("FAIL reset_alu got %h %h %h, required 0 0 f", alu_in1, alu_in2, alu_mode);
    end
    tests++;
    if (res_valid !== 1'b0 || res_data !== 8'h00 || res_mode !== 4'h0) begin
      fails++;
      $display("FAIL reset_res got %b %h %h, required 0 00 0", res_valid, res_data, res_mode);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_op();
    res_ready = 1'b1;
    set_op(4'd0, 4'd2, 4'd3);
    tick();
    s_valid = 1'b0;
    tick();
    tests++;
    if (alu_in1 !== 4'd2 || alu_in2 !== 4'd3 || alu_mode !== 4'd0) begin
      fails++;
      $display("FAIL single_issue got %h %h %h, required 2 3 0", alu_in1, alu_in2, alu_mode);
    end
    tick();
    tests++;
    if (res_valid !== 1'b1 || res_data !== 8'h05 || res_mode !== 4'd0) begin
      fails++;
      $display("FAIL single_result got %b %h %h, required 1 05 0", res_valid, res_data, res_mode);
    end
    tests++;
    if (alu_mode !== 4'hF) begin
      fails++;
      $display("FAIL single_idle got %h, required f", alu_mode);
    end
    tick();
    tests++;
    if (res_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_clear got %b, required 0", res_valid);
    end
  endtask

  task automatic test_back_to_back();
    res_ready = 1'b1;
    set_op(4'd0, 4'd2, 4'd3);
    tick();
    set_op(4'd1, 4'd3, 4'd4);
    tick();
    s_valid = 1'b0;
    tick();
    tests++;
    if (res_valid !== 1'b1 || res_data !== 8'h05) begin
      fails++;
      $display("FAIL b2b_first got %b %h, required 1 05", res_valid, res_data);
    end
    tick();
    tests++;
    if (res_valid !== 1'b1 || res_data !== 8'h0C || res_mode !== 4'd1) begin
      fails++;
      $display("FAIL b2b_second got %b %h %h, required 1 0c 1", res_valid, res_data, res_mode);
    end
    drain(4);
  endtask

  task automatic test_full();
    int accepted = 0;
    res_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_op(4'($urandom_range(0, 1)), 4'($urandom), 4'($urandom));
      if (s_ready) accepted++;
      tick();
    end
    s_valid = 1'b0;
    tests++;
    if (accepted != DEPTH + 2 || s_ready !== 1'b0 || count !== CW'(DEPTH)) begin
      fails++;
      $display("FAIL full got accepts %0d s_ready %b count %0d, required 6/0/4", accepted, s_ready, count);
    end
    drain(20);
  endtask

  task automatic test_stall();
    logic [3:0] m1, a1, b1, m2, a2, b2;
    m1 = 4'($urandom_range(0, 1)); a1 = 4'($urandom); b1 = 4'($urandom);
    m2 = 4'($urandom_range(0, 1)); a2 = 4'($urandom); b2 = 4'($urandom);
    res_ready = 1'b0;
    set_op(m1, a1, b1);
    tick();
    set_op(m2, a2, b2);
    tick();
    s_valid = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (alu_in1 !== a2 || alu_in2 !== b2 || alu_mode !== m2 ||
          res_valid !== 1'b1 || res_data !== alu_ref(m1, a1, b1)) begin
        fails++;
        $display("FAIL stall_hold cyc %0d got %h %h %h %b %h, required %h %h %h 1 %h", i,
                 alu_in1, alu_in2, alu_mode, res_valid, res_data, a2, b2, m2, alu_ref(m1, a1, b1));
      end
      tick();
    end
    drain(8);
  endtask

  task automatic test_reset_mid();
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_op(4'($urandom_range(0, 1)), 4'($urandom), 4'($urandom));
      tick();
    end
    s_valid = 1'b0;
    tests++;
    if (count !== CW'(3) || res_valid !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_pre got count %0d res_valid %b, required 3/1", count, res_valid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if (count !== '0 || res_valid !== 1'b0 || alu_mode !== 4'hF || s_ready !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_post got count %0d res_valid %b alu_mode %h s_ready %b, required 0/0/f/1",
               count, res_valid, alu_mode, s_ready);
    end
    res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (res_valid !== 1'b0) begin
        fails++;
        $display("FAIL rstmid_stale got res_valid %b data %h, required 0", res_valid, res_data);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      s_valid   = ($urandom_range(0, 99) < 60);
      s_mode    = 4'($urandom);
      s_in1     = 4'($urandom);
      s_in2     = 4'($urandom);
      res_ready = ($urandom_range(0, 99) < 55);
      tick();
    end
    drain(20);
  endtask

`ifdef ALU_ISSUE_STATS_EN
  task automatic test_stats();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    res_ready = 1'b0;
    tests++;
    if (ops_done !== 16'd0 || stall_cycles !== 16'd0) begin
      fails++;
      $display("FAIL stats_reset got %0d %0d, required 0 0", ops_done, stall_cycles);
    end
    for (int i = 0; i < 3; i++) begin
      set_op(4'd0, 4'(i), 4'd1);
      tick();
    end
    s_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    tests++;
    if (ops_done !== 16'd3 || stall_cycles !== 16'd5) begin
      fails++;
      $display("FAIL stats_count got ops %0d stalls %0d, required 3 5", ops_done, stall_cycles);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_in1 = '0; s_in2 = '0; s_mode = '0; res_ready = 1'b0;
    #1;
    test_reset();
    test_single_op();
    test_back_to_back();
    test_full();
    test_stall();
    test_reset_mid();
    test_random();
`ifdef ALU_ISSUE_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
